fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
Read-side controller for the 9-bit packet FIFO. It pops first-word-fall-through FIFO words and treats bit 8 as the end-of-packet marker and bits 7:0 as payload. It presents each word on a registered valid/ready byte stream for downstream consumers, and it keeps packet statistics. An enable input gates new packets only at packet boundaries, so a packet is never cut mid-stream.

Parameters:
bitsize, 9, FIFO word width; bit bitsize-1 is the last flag, the remaining bits are payload.
CNT_W, 16, width of the packet counter.
MAX_LEN, 64, maximum words per packet; used only when MAX_LEN_CHECK_EN is defined.

Ports:
clk  input  1  rising-edge clock
rstp  input  1  synchronous active-high reset
enable  input  1  permits the start of a new packet
fifo_data  input  bitsize  FIFO head word, valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  FIFO pop strobe (combinational)
out_data  output  bitsize-1  payload byte (registered)
out_last  output  1  final word of packet (registered)
out_valid  output  1  output word valid (registered)
out_ready  input  1  downstream accepts the word
busy  output  1  state==ACTIVE
pkt_count  output  CNT_W  packets fully delivered downstream
err_long  output  1  sticky oversize-packet flag (MAX_LEN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, rstp=1 at posedge): state=IDLE, out_valid=0, out_data=0, out_last=0, pkt_count=0, word_cnt=0, err_long=0. fifo_read=0 while rstp=1. Reset mid-packet discards the held word and any packet progress. The FIFO is not touched by this block.
- States:
  - IDLE: between packets.
  - ACTIVE: inside a multi-word packet.
- can_load = !out_valid || out_ready.
- fifo_read = !rstp && !fifo_empty && can_load && (state==ACTIVE || enable).
- On a posedge with fifo_read=1:
  - out_data <= fifo_data[bitsize-2:0]
  - out_last <= fifo_data[bitsize-1]
  - out_valid <= 1
- On a posedge with out_valid && out_ready && !fifo_read: out_valid <= 0.
- Back-to-back transfer: a word popped while the current word is accepted replaces it in the same cycle. This gives one word per cycle of sustained throughput.
- Latency: FIFO non-empty at cycle N (IDLE, enable=1, output free) gives out_valid=1 at cycle N+1.
- Output stability: out_data and out_last are held unchanged while out_valid=1 and out_ready=0.
- Transitions (evaluated on pops):
  - IDLE --pop with last=0--> ACTIVE.
  - IDLE --pop with last=1--> IDLE (single-word packet).
  - ACTIVE --pop with last=1--> IDLE.
  - ACTIVE --pop with last=0--> ACTIVE.
- enable is sampled only in IDLE. Dropping enable in ACTIVE has no effect until the last word is popped; then popping stops.
- pkt_count increments on out_valid && out_ready && out_last and wraps from 2^CNT_W-1 to 0.
- word_cnt: set to 1 on an IDLE pop, incremented on each ACTIVE pop, cleared when a last word is popped. Saturates at MAX_LEN.
- fifo_empty=1 mid-packet: stay in ACTIVE and wait, with no timeout.

Optional Feature:
MAX_LEN_CHECK_EN
- Defined:
  - When an ACTIVE pop would be word MAX_LEN of the packet and it has last=0, the block forces out_last=1 on that word.
  - err_long is set (sticky until reset), and the state goes to DROP.
  - In DROP, FIFO words are popped every cycle fifo_empty=0 regardless of out_ready or enable. They are discarded without asserting out_valid, up to and including the next word with last=1; then the state returns to IDLE.
  - The truncated packet counts in pkt_count when delivered.
- Undefined: no DROP state, no length limit, err_long tied 0.

Test Plan:
1. Reset, enable=1, FIFO holds {0x0A5, 0x03C, 0x1FF} (third word last), out_ready=1 -> out_data A5, 3C, FF on three consecutive cycles; out_last only on FF; pkt_count=1; busy high from the first pop until the third.
2. Backpressure: out_ready=0 for 5 cycles with a word held -> out_data and out_valid stable, fifo_read=0; then out_ready=1 -> remaining words stream one per cycle with none lost or duplicated.
3. Drop enable after the first word of a 4-word packet -> all 4 words are delivered, then fifo_read stays 0 with a following packet still in the FIFO; re-enable -> the next packet starts.
4. FIFO runs empty mid-packet for 3 cycles -> busy=1, out_valid drops after acceptance; the remaining words are delivered on refill.
5. Force pkt_count to 0xFFFF by sending 65535 single-word packets, then one more -> pkt_count wraps to 0.
6. (MAX_LEN_CHECK_EN, MAX_LEN=4) 6-word packet followed by a 1-word packet -> 4 words out with the 4th last=1, err_long=1, words 5-6 are dropped, the next packet is delivered intact, pkt_count=2.

Source files
------------

// File: rtl/fifo_reader.sv
// Read-side controller for the 9-bit packet FIFO: pops FWFT words onto a registered valid/ready byte stream.
// Optional MAX_LEN_CHECK_EN truncates packets longer than MAX_LEN words and drops their tail.
module fifo_reader #(
    parameter int bitsize = 9,
    parameter int CNT_W   = 16,
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic               enable,
    input  logic [bitsize-1:0] fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_read,
    output logic [bitsize-2:0] out_data,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_count,
    output logic               err_long
);

    localparam int WC_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef MAX_LEN_CHECK_EN
        S_DROP   = 2'd2,
`endif
        S_ACTIVE = 2'd1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [bitsize-2:0] r_out_data;
    logic               r_out_last;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_pkt_count;
    logic [WC_W-1:0]    r_word_cnt;
    logic               w_can_load;
    logic               w_fifo_read;
    logic               w_load;
    logic               w_busy;
    logic               w_in_last;
    logic               w_force_last;
    logic               w_word_last;

    assign w_in_last   = fifo_data[bitsize-1];
    assign w_word_last = w_in_last || w_force_last;

    // State register
    always_ff @(posedge clk) begin
        if (rstp) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, advanced only by pops
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load && !w_in_last) begin
                    w_state_next = S_ACTIVE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (w_load && w_in_last) begin
                    w_state_next = S_IDLE;
                end else if (w_force_last) begin
`ifdef MAX_LEN_CHECK_EN
                    w_state_next = S_DROP;
`else
                    w_state_next = S_IDLE;
`endif
                end else begin
                    w_state_next = S_ACTIVE;
                end
            end
`ifdef MAX_LEN_CHECK_EN
            S_DROP: begin
                if (w_fifo_read && w_in_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DROP;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pop strobe and load enable; enable only matters between packets
    always_comb begin
        w_can_load  = !r_out_valid || out_ready;
        w_fifo_read = 1'b0;
        w_load      = 1'b0;
        w_busy      = (r_state == S_ACTIVE);
        case (r_state)
            S_IDLE: begin
                w_fifo_read = !rstp && !fifo_empty && w_can_load && enable;
                w_load      = w_fifo_read;
            end
            S_ACTIVE: begin
                w_fifo_read = !rstp && !fifo_empty && w_can_load;
                w_load      = w_fifo_read;
            end
`ifdef MAX_LEN_CHECK_EN
            S_DROP: begin
                w_fifo_read = !rstp && !fifo_empty;
                w_load      = 1'b0;
            end
`endif
            default: begin
                w_fifo_read = 1'b0;
                w_load      = 1'b0;
            end
        endcase
    end

`ifdef MAX_LEN_CHECK_EN
    // Word MAX_LEN of a packet without its own last flag gets truncated here
    assign w_force_last = (r_state == S_ACTIVE) && w_load && !w_in_last &&
                          (r_word_cnt == WC_W'(MAX_LEN - 1));

    // Sticky oversize flag
    always_ff @(posedge clk) begin
        if (rstp) begin
            err_long <= 1'b0;
        end else if (w_force_last) begin
            err_long <= 1'b1;
        end else begin
            err_long <= err_long;
        end
    end
`else
    assign w_force_last = 1'b0;
    assign err_long     = 1'b0;
`endif

    // Output word register; a pop during acceptance replaces the word in place
    always_ff @(posedge clk) begin
        if (rstp) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= fifo_data[bitsize-2:0];
            r_out_last  <= w_word_last;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Delivered-packet counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rstp) begin
            r_pkt_count <= '0;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
        end else begin
            r_pkt_count <= r_pkt_count;
        end
    end

    // Words popped in the current packet, saturating at MAX_LEN
    always_ff @(posedge clk) begin
        if (rstp) begin
            r_word_cnt <= '0;
        end else if (w_load && w_word_last) begin
            r_word_cnt <= '0;
        end else if (w_load && (r_state == S_IDLE)) begin
            r_word_cnt <= WC_W'(1);
        end else if (w_load && (r_word_cnt != WC_W'(MAX_LEN))) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
        end else begin
            r_word_cnt <= r_word_cnt;
        end
    end

    assign fifo_read = w_fifo_read;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus randomized traffic against a
// packet-level reference model; FIFO is a queue popped by the DUT's fifo_read.
module tb_fifo_reader;

`ifdef MAX_LEN_CHECK_EN
    localparam int ML = 4;
`else
    localparam int ML = 64;
`endif

    logic        clk = 1'b0;
    logic        rstp, enable, fifo_empty, out_ready;
    logic [8:0]  fifo_data;
    logic        fifo_read, out_last, out_valid, busy, err_long;
    logic [7:0]  out_data;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    fifo_reader #(.bitsize(9), .CNT_W(16), .MAX_LEN(ML)) dut (
        .clk(clk), .rstp(rstp), .enable(enable), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_read(fifo_read), .out_data(out_data),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .pkt_count(pkt_count), .err_long(err_long)
    );

    logic [8:0] fifo_q[$];
    logic [8:0] src_q[$];
    logic [8:0] dut_log[$];
    int errors = 0;
    int checks = 0;

    // reference model: held word, packet position, drop mode, counters
    bit         m_valid, m_last, m_inpkt, m_drop, m_err, exp_read;
    logic [7:0] m_data;
    int         m_cnt, m_wc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 9'h000 : fifo_q[0];
    endtask

    task automatic push(input logic [8:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_last = 1'b0; m_inpkt = 1'b0; m_drop = 1'b0; m_err = 1'b0;
        m_data = 8'h00; m_cnt = 0; m_wc = 0;
    endtask

    task automatic tick();
        logic [8:0] w;
        bit rd;
        @(negedge clk);
        exp_read = !rstp && (fifo_q.size() > 0) &&
                   (m_drop || ((!m_valid || out_ready) && (m_inpkt || enable)));
        chk("fifo_read", {31'd0, fifo_read}, {31'd0, exp_read});
        rd = fifo_read;
        if (out_valid && out_ready && !rstp) dut_log.push_back({out_last, out_data});
        w = (fifo_q.size() > 0) ? fifo_q[0] : 9'h000;
        @(posedge clk);
        if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (rstp) begin
            model_reset();
        end else begin
            if (m_valid && out_ready && m_last) m_cnt = (m_cnt + 1) & 32'hFFFF;
            if (exp_read && !m_drop) begin
                m_valid = 1'b1;
                m_data  = w[7:0];
                m_last  = w[8];
                m_wc    = m_inpkt ? m_wc + 1 : 1;
`ifdef MAX_LEN_CHECK_EN
                if (m_inpkt && !w[8] && m_wc == ML) begin
                    m_last = 1'b1; m_err = 1'b1; m_drop = 1'b1;
                end
`endif
                m_inpkt = !m_last;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (exp_read && w[8]) m_drop = 1'b0;
            end
        end
        #1;
        drive_fifo();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
        chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
        chk("busy",      {31'd0, busy},      {31'd0, m_inpkt});
        chk("pkt_count", {16'd0, pkt_count}, m_cnt);
        chk("err_long",  {31'd0, err_long},  {31'd0, m_err});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rstp = 1'b1; enable = 1'b0; out_ready = 1'b0;
        model_reset();
        drive_fifo();
        run(3);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_count", {16'd0, pkt_count}, 32'd0);
        rstp = 1'b0;

        // basic three-word packet, one word per cycle
        enable = 1'b1; out_ready = 1'b1;
        dut_log.delete();
        push(9'h0A5); push(9'h03C); push(9'h1FF);
        tick();
        chk("latency", {31'd0, out_valid}, 32'd1);
        run(5);
        chk("t1_len", dut_log.size(), 32'd3);
        if (dut_log.size() == 3) begin
            chk("t1_w0", dut_log[0], 32'h0A5);
            chk("t1_w1", dut_log[1], 32'h03C);
            chk("t1_w2", dut_log[2], 32'h1FF);
        end
        chk("t1_count", {16'd0, pkt_count}, 32'd1);
        chk("t1_model", m_cnt, 32'd1);

        // backpressure holds the word
        dut_log.delete();
        out_ready = 1'b0;
        push(9'h011); push(9'h022); push(9'h133);
        run(6);
        chk("t2_hold_data", {24'd0, out_data}, 32'h11);
        chk("t2_fifo_left", fifo_q.size(), 32'd2);
        out_ready = 1'b1;
        run(5);
        chk("t2_len", dut_log.size(), 32'd3);
        if (dut_log.size() == 3) chk("t2_w2", dut_log[2], 32'h133);

        // enable dropped mid-packet
        dut_log.delete();
        push(9'h041); push(9'h042); push(9'h043); push(9'h144); push(9'h155);
        tick();
        enable = 1'b0;
        run(8);
        chk("t3_len", dut_log.size(), 32'd4);
        chk("t3_fifo_left", fifo_q.size(), 32'd1);
        enable = 1'b1;
        run(3);
        chk("t3_len2", dut_log.size(), 32'd5);
        if (dut_log.size() == 5) chk("t3_w4", dut_log[4], 32'h155);

        // FIFO underrun mid-packet
        dut_log.delete();
        push(9'h061); push(9'h062);
        run(4);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        run(3);
        push(9'h063); push(9'h164);
        run(4);
        chk("t4_len", dut_log.size(), 32'd4);
        if (dut_log.size() == 4) chk("t4_w3", dut_log[3], 32'h164);

`ifdef MAX_LEN_CHECK_EN
        // oversize packet truncated, tail dropped
        rstp = 1'b1; run(1); rstp = 1'b0;
        dut_log.delete();
        push(9'h071); push(9'h072); push(9'h073); push(9'h074); push(9'h075); push(9'h176);
        push(9'h180);
        run(20);
        chk("t6_len", dut_log.size(), 32'd5);
        if (dut_log.size() == 5) begin
            chk("t6_w3", dut_log[3], 32'h174);
            chk("t6_w4", dut_log[4], 32'h180);
        end
        chk("t6_err", {31'd0, err_long}, 32'd1);
        chk("t6_count", {16'd0, pkt_count}, 32'd2);
`endif

        // randomized traffic
        for (int p = 0; p < 400; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++)
                src_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            rstp      = ($urandom_range(0, 499) == 0);
            if (src_q.size() > 0 && $urandom_range(0, 9) < 6) push(src_q.pop_front());
            tick();
        end
        rstp = 1'b0; enable = 1'b1; out_ready = 1'b1;
        while (src_q.size() > 0) push(src_q.pop_front());
        run(200);
        chk("rand_drained", fifo_q.size(), 32'd0);

        // counter wrap
        rstp = 1'b1; run(1); rstp = 1'b0;
        for (int i = 0; i < 65535; i++) fifo_q.push_back({1'b1, 8'(i)});
        drive_fifo();
        run(65540);
        chk("t5_full", {16'd0, pkt_count}, 32'hFFFF);
        push(9'h1AA);
        run(3);
        chk("t5_wrap", {16'd0, pkt_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
